// File: rtl/wbu_sb_pkg.sv
// Shared constants and register-index helpers for the WBU issue scoreboard.
package wbu_sb_pkg;
   localparam int ADDR_WIDTH   = 5;
   localparam int NREG         = 16;
   localparam int PEND_W       = 2;
   localparam int MAX_INFLIGHT = 4;
   localparam int CNT_W        = 3;

   // RV32E has 16 registers, so the top address bit never selects anything.
   function automatic logic [3:0] reg_idx(input logic [ADDR_WIDTH-1:0] addr);
      return addr[3:0];
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
      return reg_idx(addr) == 4'd0;
   endfunction
endpackage

// File: rtl/wbu_scoreboard_pend_counter.sv
// Per-register outstanding-write counter: holds on simultaneous inc/dec,
// never wraps below zero.
module sb_pend_counter #(
   parameter int PEND_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] cnt,
   output logic              is_zero,
   output logic              is_max,
   output logic              underflow
);
   logic [PEND_W-1:0] cnt_q, cnt_d;

   assign cnt       = cnt_q;
   assign is_zero   = (cnt_q == '0);
   assign is_max    = &cnt_q;
   assign underflow = dec & is_zero;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)
         cnt_d = cnt_q + 1'b1;
      else if (dec && !inc && !is_zero)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/wbu_scoreboard.sv
// Issue-side RAW/capacity hazard controller for the RV32E register file;
// tracks in-flight destinations from IDU issue to WBU commit.
module wbu_scoreboard #(
   parameter int ADDR_WIDTH   = 5,
   parameter int NREG         = 16,
   parameter int PEND_W       = 2,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic                  issue_rs1_used,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   input  logic                  issue_rs2_used,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  issue_rd_wen,
   input  logic                  wb_valid,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic                  wb_wen,
   output logic                  stall_raw,
   output logic [NREG-1:0]       busy_mask,
   output logic [CNT_W-1:0]      inflight,
   output logic                  sb_error
);
   import wbu_sb_pkg::*;

   logic [NREG-1:0]             inc, dec, busy, at_max, uflow;
   logic [NREG-1:0][PEND_W-1:0] pend;
   logic                        raw, sat, fire;
   logic [CNT_W-1:0]            inflight_q, inflight_d;
   logic                        sb_error_q, sb_error_d;
   logic                        unused_sb;

   // x0 is never tracked, so slot 0 reads as permanently idle.
   assign busy[0]   = 1'b0;
   assign at_max[0] = 1'b0;
   assign uflow[0]  = 1'b0;
   assign pend[0]   = '0;

   for (genvar i = 1; i < NREG; i++) begin : g_pend
      logic cnt_zero;
      sb_pend_counter #(.PEND_W(PEND_W)) u_cnt (
         .clock    (clock),
         .reset    (reset),
         .inc      (inc[i]),
         .dec      (dec[i]),
         .cnt      (pend[i]),
         .is_zero  (cnt_zero),
         .is_max   (at_max[i]),
         .underflow(uflow[i])
      );
      assign busy[i] = ~cnt_zero;
   end

   assign unused_sb = ^{inc[0], dec[0], pend};

   // Hazards look only at registered state: a same-cycle retire does not bypass.
   assign raw = (issue_rs1_used & busy[reg_idx(issue_rs1)]) |
                (issue_rs2_used & busy[reg_idx(issue_rs2)]);
   assign sat = issue_rd_wen & at_max[reg_idx(issue_rd)];

   assign issue_ready = ~raw & ~sat & (inflight_q < CNT_W'(MAX_INFLIGHT));
   assign fire        = issue_valid & issue_ready;
   assign stall_raw   = issue_valid & raw;
   assign busy_mask   = busy;
   assign inflight    = inflight_q;
   assign sb_error    = sb_error_q;

   always_comb begin
      inc = '0;
      dec = '0;
      if (fire && issue_rd_wen && !is_zero_reg(issue_rd))
         inc[reg_idx(issue_rd)] = 1'b1;
      if (wb_valid && wb_wen && !is_zero_reg(wb_rd))
         dec[reg_idx(wb_rd)] = 1'b1;
   end

   always_comb begin
      inflight_d = inflight_q;
      if (fire && !wb_valid)
         inflight_d = inflight_q + 1'b1;
      else if (wb_valid && !fire && inflight_q != '0)
         inflight_d = inflight_q - 1'b1;
      sb_error_d = sb_error_q | (wb_valid & (inflight_q == '0)) | (|uflow);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inflight_q <= '0;
         sb_error_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         sb_error_q <= sb_error_d;
      end
   end
endmodule

// File: tb/tb_wbu_scoreboard.sv
// Directed bench for wbu_scoreboard with a per-cycle reference model.
module tb_wbu_scoreboard;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_wen;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
   logic        wb_valid, wb_wen;
   logic        issue_ready, stall_raw, sb_error;
   logic [15:0] busy_mask;
   logic [2:0]  inflight;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   int pend_m[16];
   int np[16];
   int infl_m = 0;
   bit err_m  = 0;

   wbu_scoreboard dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
      .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
      .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
      .stall_raw(stall_raw), .busy_mask(busy_mask),
      .inflight(inflight), .sb_error(sb_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference rules written directly from the register-level semantics.
   function automatic bit raw_f();
      int a = int'(issue_rs1[3:0]);
      int b = int'(issue_rs2[3:0]);
      return (issue_rs1_used && a != 0 && pend_m[a] != 0) ||
             (issue_rs2_used && b != 0 && pend_m[b] != 0);
   endfunction

   function automatic bit ready_f();
      int d = int'(issue_rd[3:0]);
      bit sat = issue_rd_wen && d != 0 && pend_m[d] == 3;
      return !raw_f() && !sat && infl_m < 4;
   endfunction

   function automatic logic [15:0] busy_f();
      logic [15:0] m = '0;
      for (int i = 1; i < 16; i++) m[i] = (pend_m[i] != 0);
      return m;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) pend_m[i] <= 0;
         infl_m <= 0;
         err_m  <= 0;
      end else begin
         bit fire, inc, dec, e;
         int ri, wi, ni;
         fire = issue_valid && ready_f();
         ri   = int'(issue_rd[3:0]);
         wi   = int'(wb_rd[3:0]);
         inc  = fire && issue_rd_wen && ri != 0;
         dec  = wb_valid && wb_wen && wi != 0;
         e    = err_m;
         np   = pend_m;
         if (dec && pend_m[wi] == 0) e = 1;
         if (!(inc && dec && ri == wi)) begin
            if (inc) np[ri] = np[ri] + 1;
            if (dec && np[wi] > 0) np[wi] = np[wi] - 1;
         end
         ni = infl_m;
         if (wb_valid && infl_m == 0) e = 1;
         if (fire && !wb_valid) ni = infl_m + 1;
         else if (wb_valid && !fire && infl_m > 0) ni = infl_m - 1;
         pend_m <= np;
         infl_m <= ni;
         err_m  <= e;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("m_ready", {31'd0, issue_ready}, {31'd0, ready_f()});
         check("m_stall", {31'd0, stall_raw}, {31'd0, issue_valid && raw_f()});
         check("m_busy", {16'd0, busy_mask}, {16'd0, busy_f()});
         check("m_inflight", {29'd0, inflight}, 32'(infl_m));
         check("m_error", {31'd0, sb_error}, {31'd0, err_m});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0;
      issue_rs2_used = 0; issue_rd = 0; issue_rd_wen = 0;
      wb_valid = 0; wb_rd = 0; wb_wen = 0;
   endtask

   task automatic iss(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic wen);
      issue_valid = 1; issue_rs1 = rs1; issue_rs1_used = u1;
      issue_rs2 = 5'd0; issue_rs2_used = 0; issue_rd = rd; issue_rd_wen = wen;
   endtask

   task automatic wb(input logic [4:0] rd, input logic wen);
      wb_valid = 1; wb_rd = rd; wb_wen = wen;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clock);
      #1 reset = 0; chk_en = 1;
      #1;
      check("rst_ready", {31'd0, issue_ready}, 32'd1);
      check("rst_busy", {16'd0, busy_mask}, 32'h0);
      check("rst_inflight", {29'd0, inflight}, 32'd0);
      check("rst_error", {31'd0, sb_error}, 32'd0);

      // RAW on x5, no same-cycle retire bypass
      iss(5'd0, 0, 5'd5, 1); tick(); issue_valid = 0; #1;
      check("raw_busy5", {16'd0, busy_mask}, 32'h0020);
      check("raw_infl1", {29'd0, inflight}, 32'd1);
      iss(5'd5, 1, 5'd6, 1); #1;
      check("raw_ready", {31'd0, issue_ready}, 32'd0);
      check("raw_stall", {31'd0, stall_raw}, 32'd1);
      wb(5'd5, 1); #1;
      check("raw_nobypass", {31'd0, issue_ready}, 32'd0);
      tick(); wb_valid = 0; #1;
      check("raw_cleared", {31'd0, issue_ready}, 32'd1);
      tick(); issue_valid = 0; #1;
      check("raw_busy6", {16'd0, busy_mask}, 32'h0040);
      wb(5'd6, 1); tick(); idle(); #1;
      check("raw_drain", {29'd0, inflight}, 32'd0);

      // x0 writes/reads: capacity limit only
      iss(5'd0, 1, 5'd0, 1); repeat (4) tick(); #1;
      check("cap_infl4", {29'd0, inflight}, 32'd4);
      check("cap_busy0", {16'd0, busy_mask}, 32'h0);
      check("cap_ready", {31'd0, issue_ready}, 32'd0);
      check("cap_stall", {31'd0, stall_raw}, 32'd0);
      tick();
      check("cap_held", {29'd0, inflight}, 32'd4);
      wb(5'd0, 0); #1;
      check("cap_wb_ready", {31'd0, issue_ready}, 32'd0);
      tick(); wb_valid = 0; #1;
      check("cap_infl3", {29'd0, inflight}, 32'd3);
      check("cap_ready3", {31'd0, issue_ready}, 32'd1);
      tick(); issue_valid = 0; #1;
      check("cap_fired", {29'd0, inflight}, 32'd4);
      wb(5'd0, 0); repeat (4) tick(); idle(); #1;
      check("cap_drain", {29'd0, inflight}, 32'd0);

      // WAW saturation on x7
      iss(5'd0, 0, 5'd7, 1); repeat (3) tick(); #1;
      check("waw_busy7", {16'd0, busy_mask}, 32'h0080);
      check("waw_infl3", {29'd0, inflight}, 32'd3);
      check("waw_sat", {31'd0, issue_ready}, 32'd0);
      check("waw_nostall", {31'd0, stall_raw}, 32'd0);
      wb(5'd7, 1); tick(); wb_valid = 0; #1;
      check("waw_ready", {31'd0, issue_ready}, 32'd1);
      tick(); issue_valid = 0; #1;
      check("waw_infl_again", {29'd0, inflight}, 32'd3);
      wb(5'd7, 1); repeat (3) tick(); idle(); #1;
      check("waw_drain", {16'd0, busy_mask}, 32'h0);

      // simultaneous issue and retire of x3
      iss(5'd0, 0, 5'd3, 1); tick();
      wb(5'd3, 1); #1;
      check("sim_ready", {31'd0, issue_ready}, 32'd1);
      tick(); idle(); #1;
      check("sim_busy3", {16'd0, busy_mask}, 32'h0008);
      check("sim_infl1", {29'd0, inflight}, 32'd1);
      wb(5'd3, 1); tick(); idle(); #1;
      check("sim_err0", {31'd0, sb_error}, 32'd0);

      // pend underflow on x9 with one instruction in flight
      iss(5'd0, 0, 5'd4, 1); tick(); idle();
      wb(5'd9, 1); tick(); idle(); #1;
      check("uf_err", {31'd0, sb_error}, 32'd1);
      check("uf_infl", {29'd0, inflight}, 32'd0);
      check("uf_busy", {16'd0, busy_mask}, 32'h0010);
      repeat (3) tick();
      check("uf_sticky", {31'd0, sb_error}, 32'd1);

      // asynchronous reset mid-stream
      iss(5'd0, 0, 5'd0, 1); repeat (3) tick(); idle(); #1;
      check("ar_infl3", {29'd0, inflight}, 32'd3);
      reset = 1; #1;
      check("ar_infl0", {29'd0, inflight}, 32'd0);
      check("ar_err0", {31'd0, sb_error}, 32'd0);
      check("ar_busy0", {16'd0, busy_mask}, 32'h0);
      check("ar_ready", {31'd0, issue_ready}, 32'd1);
      #1 reset = 0;

      // retire with nothing in flight
      wb(5'd0, 0); tick(); idle(); #1;
      check("if_err", {31'd0, sb_error}, 32'd1);
      check("if_infl", {29'd0, inflight}, 32'd0);
      repeat (2) tick();
      check("if_sticky", {31'd0, sb_error}, 32'd1);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wbu_scoreboard.md
Name: wbu_scoreboard

Overview:
- Issue-side hazard controller for the 16-entry RV32E register file written by the WBU.
- Tracks in-flight destination registers from IDU issue until WBU commit.
- Withholds issue on a RAW hazard or when in-flight capacity is exhausted.
- Sits between IDU (issue handshake) and WBU (retire pulse, one per completed instruction).

Parameters:
- ADDR_WIDTH, 5, architectural register index width; only bits [3:0] are used.
- NREG, 16, number of tracked registers; x0 is never tracked.
- PEND_W, 2, width of each per-register pending counter (max 3 outstanding writes per register).
- MAX_INFLIGHT, 4, maximum instructions issued but not yet retired.
- CNT_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  IDU presents a decoded instruction.
- issue_ready  out  1  scoreboard accepts it; fire = issue_valid & issue_ready.
- issue_rs1  in  ADDR_WIDTH  source register 1.
- issue_rs1_used  in  1  instruction reads rs1.
- issue_rs2  in  ADDR_WIDTH  source register 2.
- issue_rs2_used  in  1  instruction reads rs2.
- issue_rd  in  ADDR_WIDTH  destination register.
- issue_rd_wen  in  1  instruction writes rd.
- wb_valid  in  1  one-cycle pulse: WBU commits one instruction this cycle (the register-file write happens on this edge).
- wb_rd  in  ADDR_WIDTH  committed destination.
- wb_wen  in  1  committed instruction wrote rd.
- stall_raw  out  1  issue_valid & RAW hazard (for perf/debug).
- busy_mask  out  NREG  bit i set when pend[i] != 0; bit 0 is always 0.
- inflight  out  CW  number of issued, unretired instructions, where CW = CNT_W.
- sb_error  out  1  sticky protocol error flag.

Behaviour:
- Register index is addr[3:0]; index 0 is never counted and never causes a hazard.
- raw = (rs1_used & rs1≠0 & pend[rs1]≠0) | (rs2_used & rs2≠0 & pend[rs2]≠0).
- sat = rd_wen & rd≠0 & pend[rd]==2^PEND_W−1.
- issue_ready = !raw & !sat & (inflight < MAX_INFLIGHT).
  - Combinational from registered state only; independent of issue_valid.
  - No same-cycle retire bypass: a wb_valid clearing the last pending write to rs only lowers raw on the next cycle, because the register file is written on that edge.
- WAW does not stall; multiple outstanding writes to one register are counted.
- On issue fire with rd_wen & rd≠0: pend[rd] +1.
- On wb_valid with wb_wen & wb_rd≠0: pend[wb_rd] −1.
- Same register incremented and decremented in the same cycle: pend unchanged.
- On issue fire: inflight +1. On wb_valid: inflight −1. Both in the same cycle: unchanged.
- Underflow is treated as an error:
  - wb_valid with inflight==0, or wb_wen with pend[wb_rd]==0 (wb_rd≠0), sets sb_error.
  - The affected counter holds at 0 (no wrap).
  - sb_error stays set until reset.
- Overflow cannot occur by construction (issue blocked); no wrap-around is ever permitted.
- issue_* inputs are don't-care when issue_valid=0; wb_* are don't-care when wb_valid=0.
- Latency:
  - Issue fire updates pend/inflight at the next edge.
  - busy_mask and inflight are registered-state views and reflect the update one cycle after fire.
- Reset (asynchronous, any time including mid-operation):
  - All pend = 0, inflight = 0, sb_error = 0.
  - Consequently busy_mask = 0, stall_raw = 0, issue_ready = 1.
  - Outstanding WBU retirements arriving after reset flag sb_error; the system resets IDU/WBU together with this block.
- No flush port. Squashed instructions must never be issued through this block.

Decomposition:
- Shared package wbu_sb_pkg:
  - NREG, PEND_W, MAX_INFLIGHT, CNT_W constants.
  - A reg_idx function (addr → [3:0]).
  - A zero-register test function.
- Sub-module sb_pend_counter:
  - One per register 1..15.
  - Inputs inc, dec; outputs cnt, is_zero, is_max, underflow.
  - Up/down counter, holds on simultaneous inc/dec, clamps at 0.
- Top level: hazard compare, inflight counter, error flag, busy_mask concatenation.

Test Plan:
- Reset then idle: issue_ready=1, busy_mask=0x0000, inflight=0, sb_error=0; assert reset mid-stream with inflight=3 → all counters 0 immediately, without waiting for a clock edge.
- Issue rd=x5 (wen) → next cycle busy_mask=0x0020; issue rs1=x5 → issue_ready=0, stall_raw=1; wb_valid wb_rd=x5 → that cycle still stalled, next cycle issue_ready=1.
- rd=x0 writes plus rs1=x0 reads: 4 issues → busy_mask=0, no stall, inflight=4, issue_ready=0; 5th issue waits until wb_valid, and fires the cycle after.
- WAW: 3 issues to x7 → pend[7]=3; 4th write to x7 → issue_ready=0 (sat); one retire of x7 → accepted next cycle.
- Simultaneous fire (rd=x3) and wb_valid (wb_rd=x3) with pend[3]=1 → pend[3] stays 1, inflight unchanged.
- wb_valid with inflight=0, or wb_rd=x9 with pend[9]=0 → sb_error=1 next cycle, counters stay 0, flag holds until reset.
